// File: rtl/spk_cls_pkg.sv
// Shared types and helpers for the spike window classifier.
package spk_cls_pkg;

    // Controller phases of one classification
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        DECIDE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Label width that stays at least one bit wide for small class counts
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Add one to v when inc is set, sticking at maxv instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        inc,
                                            input logic [31:0] maxv);
        if (inc && (v < maxv)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/spk_sat_counter_bank.sv
// Bank of N_CLASSES saturating spike counters with synchronous clear and
// a shared count enable. Class k lives at counts[CNT_W*k +: CNT_W].
module spk_sat_counter_bank
    import spk_cls_pkg::*;
#(
    parameter int N_CLASSES = 2,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic [N_CLASSES-1:0]         inc,
    output logic [N_CLASSES*CNT_W-1:0]   counts
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    // Clear wins over counting; each class adds its own spike bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counts <= '0;
        end else if (clear) begin
            counts <= '0;
        end else if (en) begin
            for (int k = 0; k < N_CLASSES; k++) begin
                counts[CNT_W*k +: CNT_W] <=
                    CNT_W'(sat_inc(32'(counts[CNT_W*k +: CNT_W]), inc[k], CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/spike_window_classifier.sv
// Spike window classifier: resets the network, counts output spikes per
// class over a fixed window, then scans for the argmax (lowest index wins
// ties) and presents it on a valid/ready handshake.
// Optional build macro SPK_CLASSIFY_EARLY_EXIT_EN ends the window as soon as
// the leader can no longer be overtaken and adds the early_exit output.
//
// Handshakes: start is taken on a rising edge where start && ready; the
// label is consumed on a rising edge where label_valid && label_ready.
// label_valid never drops before it is consumed, and label/tie/counts do
// not change while it is high.
module spike_window_classifier
    import spk_cls_pkg::*;
#(
    parameter int N_CLASSES = 2,
    parameter int WINDOW    = 15,
    parameter int SETTLE    = 1,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = idx_w(N_CLASSES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       ready,
    input  logic [N_CLASSES-1:0]       spk_in,
    output logic                       net_reset,
    output logic                       label_valid,
    input  logic                       label_ready,
    output logic [IDX_W-1:0]           label,
    output logic                       tie,
    output logic [N_CLASSES*CNT_W-1:0] counts,
`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
    output logic                       early_exit,
`endif
    output logic [2:0]                 dbg_state
);

    state_t            state_q, state_d;
    logic [31:0]       phase_q;
    logic              accept;
    logic              ee_hit;
    logic [CNT_W-1:0]  best_q, cur, nb;
    logic [IDX_W-1:0]  idx_q, ni;
    logic              tie_q, nt;

    assign accept = (state_q == IDLE) && start;

    spk_sat_counter_bank #(
        .N_CLASSES (N_CLASSES),
        .CNT_W     (CNT_W)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .en     (state_q == RUN),
        .inc    (spk_in),
        .counts (counts)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: each timed phase ends when its phase counter hits the last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   if (phase_q == 32'(SETTLE - 1)) state_d = RUN;
            RUN:     if ((phase_q == 32'(WINDOW - 1)) || ee_hit) state_d = DECIDE;
            DECIDE:  if (phase_q == 32'(N_CLASSES - 1)) state_d = HOLD;
            HOLD:    if (label_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the current state
    always_comb begin
        ready       = (state_q == IDLE);
        net_reset   = (state_q != RUN);
        label_valid = (state_q == HOLD);
        dbg_state   = state_q;
    end

    // Cycle counter within CLEAR/RUN/DECIDE, restarting on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (state_d != state_q) begin
            phase_q <= '0;
        end else if ((state_q == CLEAR) || (state_q == RUN) || (state_q == DECIDE)) begin
            phase_q <= phase_q + 32'd1;
        end
    end

    // One scan step: class phase_q against the running best
    always_comb begin
        cur = '0;
        for (int k = 0; k < N_CLASSES; k++) begin
            if (phase_q == 32'(k)) cur = counts[CNT_W*k +: CNT_W];
        end
        nb = best_q;
        ni = idx_q;
        nt = tie_q;
        if (phase_q == 32'd0) begin
            nb = cur;
            ni = '0;
            nt = 1'b0;
        end else if (cur > best_q) begin
            nb = cur;
            ni = phase_q[IDX_W-1:0];
            nt = 1'b0;
        end else if (cur == best_q) begin
            nt = 1'b1;
        end
    end

    // Scan registers advance in DECIDE; published outputs load on the final step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q <= '0;
            idx_q  <= '0;
            tie_q  <= 1'b0;
            label  <= '0;
            tie    <= 1'b0;
        end else if (state_q == DECIDE) begin
            best_q <= nb;
            idx_q  <= ni;
            tie_q  <= nt;
            if (phase_q == 32'(N_CLASSES - 1)) begin
                label <= ni;
                tie   <= nt;
            end
        end
    end

`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic              ee_flag;
    logic [CNT_W-1:0]  top, second, v;
    logic [31:0]       remaining;

    // Leader vs runner-up on this cycle's updated counts; stop if unreachable
    always_comb begin
        top       = '0;
        second    = '0;
        v         = '0;
        ee_hit    = 1'b0;
        for (int k = 0; k < N_CLASSES; k++) begin
            v = CNT_W'(sat_inc(32'(counts[CNT_W*k +: CNT_W]), spk_in[k], CNT_MAX));
            if (v > top) begin
                second = top;
                top    = v;
            end else if (v > second) begin
                second = v;
            end
        end
        remaining = 32'(WINDOW) - phase_q - 32'd1;
        if ((state_q == RUN) && (remaining != 32'd0) &&
            (32'(top) > (32'(second) + remaining))) begin
            ee_hit = 1'b1;
        end
    end

    // Remember a cut-short window and publish it together with the label
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ee_flag    <= 1'b0;
            early_exit <= 1'b0;
        end else begin
            if (accept) ee_flag <= 1'b0;
            else if (ee_hit) ee_flag <= 1'b1;
            if ((state_q == DECIDE) && (phase_q == 32'(N_CLASSES - 1))) early_exit <= ee_flag;
        end
    end
`else
    assign ee_hit = 1'b0;
`endif

endmodule

// File: tb/tb_spike_window_classifier.sv
// Self-checking bench for spike_window_classifier: directed examples plus
// randomized spike trains compared against a count-and-argmax model.
module tb_spike_window_classifier;

    localparam int TB_N   = 4;
    localparam int TB_W   = 15;
    localparam int TB_S   = 2;
    localparam int TB_C   = 3;
    localparam int TB_I   = 2;
    localparam int TB_MAX = 7;
    localparam int REC_W  = 2 + TB_I + TB_N*TB_C;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic                   ready;
    logic [TB_N-1:0]        spk_in;
    logic                   net_reset;
    logic                   label_valid;
    logic                   label_ready;
    logic [TB_I-1:0]        label;
    logic                   tie;
    logic [TB_N*TB_C-1:0]   counts;
    logic [2:0]             dbg_state;
`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
    logic                   early_exit;
`endif

    int checks = 0;
    int errors = 0;
    logic [REC_W-1:0] exp_q[$];

    spike_window_classifier #(
        .N_CLASSES (TB_N),
        .WINDOW    (TB_W),
        .SETTLE    (TB_S),
        .CNT_W     (TB_C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .spk_in      (spk_in),
        .net_reset   (net_reset),
        .label_valid (label_valid),
        .label_ready (label_ready),
        .label       (label),
        .tie         (tie),
        .counts      (counts),
`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
        .early_exit  (early_exit),
`endif
        .dbg_state   (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TB_N-1:0] gen(input logic [TB_N-1:0] mask, input int prob);
        logic [TB_N-1:0] g;
        for (int k = 0; k < TB_N; k++) begin
            g[k] = mask[k] && (int'($urandom_range(0, 99)) < prob);
        end
        return g;
    endfunction

    // One full example: start, drive spikes every cycle, model the window,
    // check latency and results, apply hold_cycles of backpressure, release.
    task automatic run_example(input logic [TB_N-1:0] mask, input int prob, input int hold_cycles);
        int               mc[TB_N];
        int               m, run_c, exp_lat, best, lbl, others;
        bit               exited, run_done, timed_out;
        logic [TB_N-1:0]  s;
        logic [TB_N*TB_C-1:0] ev;
        logic [REC_W-1:0] rec, got;
        int               sq[$];

        @(negedge clk);
        check("ready_before_start", 64'(ready), 64'd1);
        start  = 1'b1;
        spk_in = gen(mask, prob);
        foreach (mc[k]) mc[k] = 0;
        exited    = 1'b0;
        run_c     = 0;
        exp_lat   = TB_S + TB_W + TB_N;
        m         = 0;
        timed_out = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (label_valid) break;
            if (m > TB_S + TB_W + TB_N + 5) begin
                timed_out = 1'b1;
                break;
            end
            run_done = exited || (run_c == TB_W);
            check("net_reset_phase", 64'(net_reset), 64'(!((m >= TB_S) && !run_done)));
            s      = gen(mask, prob);
            spk_in = s;
            if ((m + 1 >= TB_S + 1) && !run_done) begin
                for (int k = 0; k < TB_N; k++) begin
                    mc[k] = (mc[k] + int'(s[k]) > TB_MAX) ? TB_MAX : mc[k] + int'(s[k]);
                end
                run_c++;
`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
                sq = {};
                foreach (mc[k]) sq.push_back(mc[k]);
                sq.sort();
                if ((run_c < TB_W) && (sq[TB_N-1] > sq[TB_N-2] + (TB_W - run_c))) begin
                    exited  = 1'b1;
                    exp_lat = TB_S + run_c + TB_N;
                end
`endif
            end
            m++;
        end
        check("label_valid_timeout", 64'(timed_out), 64'd0);
        check("latency", 64'(m), 64'(exp_lat));

        best = 0;
        foreach (mc[k]) if (mc[k] > best) best = mc[k];
        lbl = -1;
        others = -1;
        foreach (mc[k]) begin
            if (mc[k] == best) begin
                others++;
                if (lbl < 0) lbl = k;
            end
        end
        for (int k = 0; k < TB_N; k++) ev[TB_C*k +: TB_C] = TB_C'(mc[k]);
        exp_q.push_back({exited, (others > 0), TB_I'(lbl), ev});

        rec = exp_q.pop_front();
        check("label", 64'(label), 64'(rec[TB_N*TB_C +: TB_I]));
        check("tie", 64'(tie), 64'(rec[TB_N*TB_C + TB_I]));
        check("counts", 64'(counts), 64'(rec[TB_N*TB_C-1:0]));
`ifdef SPK_CLASSIFY_EARLY_EXIT_EN
        check("early_exit", 64'(early_exit), 64'(rec[REC_W-1]));
`endif
        got = rec;

        for (int i = 0; i < hold_cycles; i++) begin
            start  = 1'b1;
            spk_in = gen(4'hf, 50);
            @(negedge clk);
            check("hold_valid", 64'(label_valid), 64'd1);
            check("hold_ready", 64'(ready), 64'd0);
            check("hold_outputs", 64'({tie, label, counts}), 64'(got[TB_N*TB_C + TB_I:0]));
        end
        start       = 1'b0;
        label_ready = 1'b1;
        @(negedge clk);
        label_ready = 1'b0;
        check("release_valid", 64'(label_valid), 64'd0);
        check("release_ready", 64'(ready), 64'd1);
        check("idle_retain", 64'({tie, label, counts}), 64'(got[TB_N*TB_C + TB_I:0]));
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        label_ready = 1'b0;
        spk_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_net_reset", 64'(net_reset), 64'd1);
        check("rst_label_valid", 64'(label_valid), 64'd0);
        check("rst_label_tie", 64'({label, tie}), 64'd0);
        check("rst_counts", 64'(counts), 64'd0);
        reset = 1'b1;

        // single class, saturating at 7 over the 15-cycle window
        run_example(4'b0010, 100, 10);
        // silence: all zero, label 0 with a tie
        run_example(4'b0000, 100, 0);
        // two saturated classes tie; lower index wins
        run_example(4'b0110, 100, 1);
        // lone top class firing sparsely
        run_example(4'b1000, 50, 2);
        // steady class 0 (early exit build cuts the window)
        run_example(4'b0001, 100, 0);

        // asynchronous abort in the middle of RUN
        @(negedge clk);
        start  = 1'b1;
        spk_in = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        repeat (TB_S + 5) @(negedge clk);
        check("abort_counting", 64'(net_reset), 64'd0);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_net_reset", 64'(net_reset), 64'd1);
        check("abort_counts", 64'(counts), 64'd0);
        check("abort_label_tie_valid", 64'({label, tie, label_valid}), 64'd0);
        @(negedge clk);
        reset  = 1'b1;
        spk_in = '0;
        for (int i = 0; i < TB_S + TB_W + TB_N + 3; i++) begin
            @(negedge clk);
            check("abort_no_label", 64'({label_valid, ready}), 64'b01);
        end
        run_example(4'b0101, 80, 1);

        // randomized examples
        for (int i = 0; i < 20; i++) begin
            run_example(TB_N'($urandom_range(0, 15)), int'($urandom_range(10, 90)),
                        int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
